// File: rtl/branch_pkg.sv
// Shared encodings for the 2-bit branch history counters.
package branch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } bht_cnt_e;

    localparam bht_cnt_e CNT_RESET = WEAK_NT;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter; one instance per branch history entry.
module sat_counter2
    import branch_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     en_i,
    input  logic     up_i,
    output bht_cnt_e cnt_o
);

    bht_cnt_e cnt_q, cnt_d;

    function automatic bht_cnt_e sat_step(input bht_cnt_e c, input logic up);
        bht_cnt_e r;
        r = c;
        if (up && (c != STRONG_T)) begin
            r = bht_cnt_e'(c + 2'd1);
        end else if (!up && (c != STRONG_NT)) begin
            r = bht_cnt_e'(c - 2'd1);
        end
        return r;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = sat_step(cnt_q, up_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CNT_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: fetch-stage prediction, execute-stage resolve,
// one-cycle flush/redirect on mispredict, and branch/mispredict statistics.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic        if_is_branch,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_count,
    output logic [15:0] mp_count
);

    logic [1:0]       cnt [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             qual, mispred;

    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic [15:0] br_q, br_d, mp_q, mp_d;

    logic        unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // A resolve arriving during a flush belongs to the squashed wrong path.
    assign qual    = ex_valid && !flush_q;
    assign mispred = qual && (ex_taken != ex_pred_taken);

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        bht_cnt_e cnt_e;
        sat_counter2 u_cnt (
            .clk_i  (clk),
            .rst_ni (reset),
            .en_i   (qual && (ex_idx == IDX_W'(g))),
            .up_i   (ex_taken),
            .cnt_o  (cnt_e)
        );
        assign cnt[g] = cnt_e;
    end

    assign pred_taken = if_is_branch && cnt[if_idx][1];

    always_comb begin
        flush_d    = mispred;
        redirect_d = redirect_q;
        br_d       = br_q;
        mp_d       = mp_q;
        if (mispred) begin
            redirect_d = ex_taken ? ex_target : (ex_pc + 32'd4);
        end
        if (qual) begin
            br_d = br_q + 16'd1;
        end
        if (mispred) begin
            mp_d = mp_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q    <= 1'b0;
            redirect_q <= 32'd0;
            br_q       <= 16'd0;
            mp_q       <= 16'd0;
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_q       <= br_d;
            mp_q       <= mp_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign br_count    = br_q;
    assign mp_count    = mp_q;

endmodule
